// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the memory port.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [31:0]           if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [3:0]            ls_be_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [31:0]           ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [31:0]           ls_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  logic                  busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_be_i,
    input  ls_addr_i, ls_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wdata_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_be_i,
    output ls_addr_i, ls_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wdata_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin IF/LS arbiter for a single-port memory, one transaction in flight.
// Define ARB_STALL_CNT_EN to add per-requester saturating stall counters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int MEM_LATENCY      = 1,
  parameter bit RESET_LAST_GRANT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [31:0] if_stall_cnt_o,
  output logic [31:0] ls_stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam int CW = 2;
  localparam logic [CW-1:0] CntInit = CW'(MEM_LATENCY - 1);

  state_e        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          ownerLs, ownerLsNext;
  logic          ownerWe, ownerWeNext;
  logic          lastLs, lastLsNext;

  logic respValid;
  logic canIssue;
  logic gntIf;
  logic gntLs;

  // The response cycle doubles as an issue slot for back-to-back grants.
  always_comb begin
    respValid = (state == WAIT) && (cnt == '0);
    canIssue  = rst_ni && ((state == IDLE) || respValid);
    gntLs     = canIssue && bus.ls_req_i
                && (!bus.if_req_i || !lastLs);
    gntIf     = canIssue && bus.if_req_i
                && (!bus.ls_req_i || lastLs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      ownerLs <= 1'b0;
      ownerWe <= 1'b0;
      lastLs  <= RESET_LAST_GRANT;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      ownerLs <= ownerLsNext;
      ownerWe <= ownerWeNext;
      lastLs  <= lastLsNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    ownerLsNext = ownerLs;
    ownerWeNext = ownerWe;
    lastLsNext  = lastLs;
    unique case (state)
      IDLE: ;
      WAIT: begin
        if (cnt != '0) cntNext = cnt - 1'b1;
        else stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (gntIf || gntLs) begin
      stateNext   = WAIT;
      cntNext     = CntInit;
      ownerLsNext = gntLs;
      ownerWeNext = gntLs && bus.ls_we_i;
      lastLsNext  = gntLs;
    end
  end

  always_comb begin
    bus.if_gnt_o    = gntIf;
    bus.ls_gnt_o    = gntLs;
    bus.mem_req_o   = gntIf || gntLs;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    unique case (1'b1)
      gntLs: begin
        bus.mem_we_o    = bus.ls_we_i;
        bus.mem_be_o    = bus.ls_be_i;
        bus.mem_addr_o  = bus.ls_addr_i;
        bus.mem_wdata_o = bus.ls_wdata_i;
      end
      gntIf: begin
        bus.mem_be_o   = 4'hF;
        bus.mem_addr_o = bus.if_addr_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.if_rvalid_o = respValid && !ownerLs;
    bus.ls_rvalid_o = respValid && ownerLs;
    bus.if_rdata_o  = bus.if_rvalid_o
                      ? bus.mem_rdata_i : '0;
    bus.ls_rdata_o  = (bus.ls_rvalid_o && !ownerWe)
                      ? bus.mem_rdata_i : '0;
    bus.busy_o      = (state == WAIT);
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_stall_cnt_o <= '0;
      ls_stall_cnt_o <= '0;
    end else begin
      if (bus.if_req_i && !gntIf && !(&if_stall_cnt_o))
        if_stall_cnt_o <= if_stall_cnt_o + 32'd1;
      if (bus.ls_req_i && !gntLs && !(&ls_stall_cnt_o))
        ls_stall_cnt_o <= ls_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-1 and latency-3 instances,
// response scoreboard fed by the stimulus tasks.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) ia ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) ib ();

`ifdef ARB_STALL_CNT_EN
  logic [31:0] ifStallA, lsStallA, ifStallB, lsStallB;
`endif

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .MEM_LATENCY(1), .RESET_LAST_GRANT(1'b0)
  ) dutA (
    .clk_i(clk), .rst_ni(rst_n), .bus(ia)
`ifdef ARB_STALL_CNT_EN
    , .if_stall_cnt_o(ifStallA), .ls_stall_cnt_o(lsStallA)
`endif
  );

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .MEM_LATENCY(3), .RESET_LAST_GRANT(1'b0)
  ) dutB (
    .clk_i(clk), .rst_ni(rst_n), .bus(ib)
`ifdef ARB_STALL_CNT_EN
    , .if_stall_cnt_o(ifStallB), .ls_stall_cnt_o(lsStallB)
`endif
  );

  function automatic logic [31:0] memData(logic [31:0] a);
    if (a == 32'h24) return 32'h13;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory models: data appears exactly MEM_LATENCY cycles after acceptance.
  logic [31:0] pipeA = 32'h0;
  logic [31:0] pipeB [3] = '{32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    pipeA <= ia.mem_req_o ? memData(ia.mem_addr_o) : 32'hBAD0_0000;
    pipeB[0] <= ib.mem_req_o ? memData(ib.mem_addr_o) : 32'hBAD0_0001;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign ia.mem_rdata_i = pipeA;
  assign ib.mem_rdata_i = pipeB[2];

  typedef struct {
    logic        ls;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t eA, eB;

  always @(negedge clk) begin
    if (ia.if_rvalid_o || ia.ls_rvalid_o) begin
      nCmp++;
      if (qa.size() == 0) begin
        nBad++;
        $display("FAIL rspA_unexpected cyc=%0d if_rvalid=%b ls_rvalid=%b required none",
                 cyc, ia.if_rvalid_o, ia.ls_rvalid_o);
      end else begin
        eA = qa.pop_front();
        if (ia.ls_rvalid_o !== eA.ls || ia.if_rvalid_o === ia.ls_rvalid_o
            || (eA.ls ? ia.ls_rdata_o : ia.if_rdata_o) !== eA.data
            || cyc != eA.due) begin
          nBad++;
          $display("FAIL rspA cyc=%0d ls=%b if=%b data=%h required cyc=%0d ls=%b data=%h",
                   cyc, ia.ls_rvalid_o, ia.if_rvalid_o,
                   eA.ls ? ia.ls_rdata_o : ia.if_rdata_o, eA.due, eA.ls, eA.data);
        end
      end
    end
    if (ib.if_rvalid_o || ib.ls_rvalid_o) begin
      nCmp++;
      if (qb.size() == 0) begin
        nBad++;
        $display("FAIL rspB_unexpected cyc=%0d if_rvalid=%b ls_rvalid=%b required none",
                 cyc, ib.if_rvalid_o, ib.ls_rvalid_o);
      end else begin
        eB = qb.pop_front();
        if (ib.ls_rvalid_o !== eB.ls || ib.if_rvalid_o === ib.ls_rvalid_o
            || (eB.ls ? ib.ls_rdata_o : ib.if_rdata_o) !== eB.data
            || cyc != eB.due) begin
          nBad++;
          $display("FAIL rspB cyc=%0d ls=%b if=%b data=%h required cyc=%0d ls=%b data=%h",
                   cyc, ib.ls_rvalid_o, ib.if_rvalid_o,
                   eB.ls ? ib.ls_rdata_o : ib.if_rdata_o, eB.due, eB.ls, eB.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ia.if_req_i = 0; ia.if_addr_i = '0;
    ia.ls_req_i = 0; ia.ls_we_i = 0; ia.ls_be_i = '0;
    ia.ls_addr_i = '0; ia.ls_wdata_i = '0;
    ib.if_req_i = 0; ib.if_addr_i = '0;
    ib.ls_req_i = 0; ib.ls_we_i = 0; ib.ls_be_i = '0;
    ib.ls_addr_i = '0; ib.ls_wdata_i = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    ia.if_req_i = 1; ia.if_addr_i = 32'h66;
    ia.ls_req_i = 1; ia.ls_we_i = 1; ia.ls_be_i = 4'hF;
    ia.ls_addr_i = 32'h55; ia.ls_wdata_i = 32'h1234;
    ib.if_req_i = 1; ib.if_addr_i = 32'h66;
    ib.ls_req_i = 1; ib.ls_we_i = 1; ib.ls_be_i = 4'hF;
    ib.ls_addr_i = 32'h55; ib.ls_wdata_i = 32'h1234;
    @(negedge clk);
    nCmp++;
    if ({ia.if_gnt_o, ia.ls_gnt_o, ia.if_rvalid_o, ia.ls_rvalid_o,
         ia.mem_req_o, ia.mem_we_o, ia.busy_o} !== 7'b0) begin
      nBad++;
      $display("FAIL reset_ctrlA got=%b required=0000000",
               {ia.if_gnt_o, ia.ls_gnt_o, ia.if_rvalid_o, ia.ls_rvalid_o,
                ia.mem_req_o, ia.mem_we_o, ia.busy_o});
    end
    nCmp++;
    if ({ia.mem_be_o, ia.mem_addr_o, ia.mem_wdata_o,
         ia.if_rdata_o, ia.ls_rdata_o} !== '0) begin
      nBad++;
      $display("FAIL reset_dataA be=%h addr=%h wdata=%h required all 0",
               ia.mem_be_o, ia.mem_addr_o, ia.mem_wdata_o);
    end
    nCmp++;
    if ({ib.if_gnt_o, ib.ls_gnt_o, ib.if_rvalid_o, ib.ls_rvalid_o,
         ib.mem_req_o, ib.mem_we_o, ib.busy_o} !== 7'b0) begin
      nBad++;
      $display("FAIL reset_ctrlB got=%b required=0000000",
               {ib.if_gnt_o, ib.ls_gnt_o, ib.if_rvalid_o, ib.ls_rvalid_o,
                ib.mem_req_o, ib.mem_we_o, ib.busy_o});
    end
    nCmp++;
    if ({ib.mem_be_o, ib.mem_addr_o, ib.mem_wdata_o} !== '0) begin
      nBad++;
      $display("FAIL reset_dataB be=%h addr=%h wdata=%h required all 0",
               ib.mem_be_o, ib.mem_addr_o, ib.mem_wdata_o);
    end
    idleInputs();
    step();
    rst_n = 1;
  endtask

  task automatic test_single_read();
    doReset();
    step();
    ia.if_req_i = 1; ia.if_addr_i = 32'h24;
    qa.push_back('{1'b0, 32'h13, cyc + 1});
    @(negedge clk);
    nCmp++;
    if ({ia.if_gnt_o, ia.ls_gnt_o, ia.mem_req_o, ia.mem_we_o, ia.mem_be_o}
        !== 8'b1010_1111) begin
      nBad++;
      $display("FAIL single_issue got=%b required=10101111",
               {ia.if_gnt_o, ia.ls_gnt_o, ia.mem_req_o, ia.mem_we_o, ia.mem_be_o});
    end
    nCmp++;
    if ({ia.mem_addr_o, ia.mem_wdata_o} !== {32'h24, 32'h0}) begin
      nBad++;
      $display("FAIL single_addr got=%h/%h required=00000024/00000000",
               ia.mem_addr_o, ia.mem_wdata_o);
    end
    step();
    ia.if_req_i = 0;
    @(negedge clk);
    nCmp++;
    if ({ia.if_rvalid_o, ia.ls_rvalid_o, ia.if_rdata_o, ia.mem_req_o}
        !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
      nBad++;
      $display("FAIL single_rsp if_rvalid=%b ls_rvalid=%b rdata=%h mem_req=%b required 1 0 00000013 0",
               ia.if_rvalid_o, ia.ls_rvalid_o, ia.if_rdata_o, ia.mem_req_o);
    end
    step();
    @(negedge clk);
    nCmp++;
    if (ia.busy_o !== 1'b0 || qa.size() != 0) begin
      nBad++;
      $display("FAIL single_done busy=%b pending=%0d required 0 0",
               ia.busy_o, qa.size());
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    step();
    ia.if_req_i = 1; ia.if_addr_i = 32'h40;
    ia.ls_req_i = 1; ia.ls_we_i = 0; ia.ls_be_i = 4'hF;
    ia.ls_addr_i = 32'h80;
    qa.push_back('{1'b1, memData(32'h80), cyc + 1});
    @(negedge clk);
    nCmp++;
    if ({ia.if_gnt_o, ia.ls_gnt_o, ia.mem_addr_o} !== {2'b01, 32'h80}) begin
      nBad++;
      $display("FAIL b2b_tie gnt_if/ls=%b%b addr=%h required 01 00000080",
               ia.if_gnt_o, ia.ls_gnt_o, ia.mem_addr_o);
    end
    step();
    qa.push_back('{1'b0, memData(32'h40), cyc + 1});
    @(negedge clk);
    nCmp++;
    if ({ia.if_gnt_o, ia.ls_gnt_o, ia.ls_rvalid_o, ia.busy_o, ia.mem_addr_o}
        !== {4'b1011, 32'h40}) begin
      nBad++;
      $display("FAIL b2b_rr got=%b addr=%h required 1011 00000040",
               {ia.if_gnt_o, ia.ls_gnt_o, ia.ls_rvalid_o, ia.busy_o}, ia.mem_addr_o);
    end
    step();
    ia.if_req_i = 0; ia.ls_addr_i = 32'h84;
    qa.push_back('{1'b1, memData(32'h84), cyc + 1});
    @(negedge clk);
    nCmp++;
    if ({ia.if_gnt_o, ia.ls_gnt_o, ia.if_rvalid_o, ia.mem_addr_o}
        !== {3'b011, 32'h84}) begin
      nBad++;
      $display("FAIL b2b_ls_again got=%b addr=%h required 011 00000084",
               {ia.if_gnt_o, ia.ls_gnt_o, ia.if_rvalid_o}, ia.mem_addr_o);
    end
    step();
    ia.ls_req_i = 0;
    step();
    @(negedge clk);
    nCmp++;
    if (ia.busy_o !== 1'b0 || qa.size() != 0) begin
      nBad++;
      $display("FAIL b2b_done busy=%b pending=%0d required 0 0",
               ia.busy_o, qa.size());
    end
  endtask

  task automatic test_write();
    doReset();
    step();
    ia.ls_req_i = 1; ia.ls_we_i = 1; ia.ls_be_i = 4'b0011;
    ia.ls_addr_i = 32'h100; ia.ls_wdata_i = 32'hDEADBEEF;
    qa.push_back('{1'b1, 32'h0, cyc + 1});
    @(negedge clk);
    nCmp++;
    if ({ia.ls_gnt_o, ia.mem_req_o, ia.mem_we_o, ia.mem_be_o} !== 7'b111_0011) begin
      nBad++;
      $display("FAIL write_ctrl got=%b required=1110011",
               {ia.ls_gnt_o, ia.mem_req_o, ia.mem_we_o, ia.mem_be_o});
    end
    nCmp++;
    if ({ia.mem_addr_o, ia.mem_wdata_o} !== {32'h100, 32'hDEADBEEF}) begin
      nBad++;
      $display("FAIL write_data got=%h/%h required=00000100/deadbeef",
               ia.mem_addr_o, ia.mem_wdata_o);
    end
    step();
    ia.ls_req_i = 0; ia.ls_we_i = 0;
    @(negedge clk);
    nCmp++;
    if ({ia.ls_rvalid_o, ia.ls_rdata_o, ia.mem_req_o, ia.mem_we_o, ia.mem_wdata_o}
        !== {1'b1, 32'h0, 2'b00, 32'h0}) begin
      nBad++;
      $display("FAIL write_rsp rvalid=%b rdata=%h mem_we=%b wdata=%h required 1 0 0 0",
               ia.ls_rvalid_o, ia.ls_rdata_o, ia.mem_we_o, ia.mem_wdata_o);
    end
    step();
  endtask

  task automatic test_latency();
    doReset();
    step();
    ib.if_req_i = 1; ib.if_addr_i = 32'h200;
    qb.push_back('{1'b0, memData(32'h200), cyc + 3});
    @(negedge clk);
    nCmp++;
    if ({ib.if_gnt_o, ib.mem_addr_o} !== {1'b1, 32'h200}) begin
      nBad++;
      $display("FAIL lat_issue gnt=%b addr=%h required 1 00000200",
               ib.if_gnt_o, ib.mem_addr_o);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      ib.if_req_i = 0;
      ib.ls_req_i = 1; ib.ls_we_i = 0; ib.ls_be_i = 4'hF;
      ib.ls_addr_i = 32'h300;
      @(negedge clk);
      nCmp++;
      if ({ib.ls_gnt_o, ib.if_gnt_o, ib.mem_req_o, ib.busy_o, ib.mem_addr_o}
          !== {4'b0001, 32'h0}) begin
        nBad++;
        $display("FAIL lat_hold c%0d got=%b addr=%h required 0001 0",
                 k, {ib.ls_gnt_o, ib.if_gnt_o, ib.mem_req_o, ib.busy_o}, ib.mem_addr_o);
      end
    end
    step();
    qb.push_back('{1'b1, memData(32'h300), cyc + 3});
    @(negedge clk);
    nCmp++;
    if ({ib.if_rvalid_o, ib.ls_gnt_o, ib.busy_o, ib.mem_addr_o}
        !== {3'b111, 32'h300}) begin
      nBad++;
      $display("FAIL lat_resp got=%b addr=%h required 111 00000300",
               {ib.if_rvalid_o, ib.ls_gnt_o, ib.busy_o}, ib.mem_addr_o);
    end
    step();
    ib.ls_req_i = 0;
    repeat (3) step();
    @(negedge clk);
    nCmp++;
    if (ib.busy_o !== 1'b0 || qb.size() != 0) begin
      nBad++;
      $display("FAIL lat_done busy=%b pending=%0d required 0 0",
               ib.busy_o, qb.size());
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    step();
    ib.if_req_i = 1; ib.if_addr_i = 32'h44;
    @(negedge clk);
    nCmp++;
    if (ib.if_gnt_o !== 1'b1) begin
      nBad++;
      $display("FAIL rmid_issue gnt=%b required 1", ib.if_gnt_o);
    end
    step();
    #1 rst_n = 0;
    qb.delete();
    #1;
    nCmp++;
    if ({ib.if_gnt_o, ib.busy_o, ib.mem_req_o, ib.if_rvalid_o, ib.mem_addr_o}
        !== {4'b0, 32'h0}) begin
      nBad++;
      $display("FAIL rmid_async got=%b addr=%h required 0000 0",
               {ib.if_gnt_o, ib.busy_o, ib.mem_req_o, ib.if_rvalid_o}, ib.mem_addr_o);
    end
    ib.if_req_i = 0;
    step();
    step();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nCmp++;
      if ({ib.if_rvalid_o, ib.ls_rvalid_o, ib.busy_o} !== 3'b000) begin
        nBad++;
        $display("FAIL rmid_quiet c%0d got=%b required 000",
                 k, {ib.if_rvalid_o, ib.ls_rvalid_o, ib.busy_o});
      end
      step();
    end
    ib.if_req_i = 1; ib.if_addr_i = 32'h48;
    qb.push_back('{1'b0, memData(32'h48), cyc + 3});
    @(negedge clk);
    nCmp++;
    if ({ib.if_gnt_o, ib.mem_addr_o} !== {1'b1, 32'h48}) begin
      nBad++;
      $display("FAIL rmid_regrant gnt=%b addr=%h required 1 00000048",
               ib.if_gnt_o, ib.mem_addr_o);
    end
    step();
    ib.if_req_i = 0;
    repeat (3) step();
    @(negedge clk);
    nCmp++;
    if (qb.size() != 0) begin
      nBad++;
      $display("FAIL rmid_done pending=%0d required 0", qb.size());
    end
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    doReset();
    step();
    ib.if_req_i = 1; ib.if_addr_i = 32'h400;
    ib.ls_req_i = 1; ib.ls_we_i = 0; ib.ls_be_i = 4'hF;
    ib.ls_addr_i = 32'h500;
    qb.push_back('{1'b1, memData(32'h500), cyc + 3});
    @(negedge clk);
    nCmp++;
    if ({ib.ls_gnt_o, ib.if_gnt_o, ifStallB, lsStallB} !== {2'b10, 64'h0}) begin
      nBad++;
      $display("FAIL stall_start gnt=%b%b ifcnt=%0d lscnt=%0d required 10 0 0",
               ib.ls_gnt_o, ib.if_gnt_o, ifStallB, lsStallB);
    end
    step();
    ib.ls_req_i = 0;
    step();
    step();
    qb.push_back('{1'b0, memData(32'h400), cyc + 3});
    @(negedge clk);
    nCmp++;
    if ({ib.if_gnt_o, ifStallB, lsStallB} !== {1'b1, 32'd3, 32'd0}) begin
      nBad++;
      $display("FAIL stall_count gnt=%b ifcnt=%0d lscnt=%0d required 1 3 0",
               ib.if_gnt_o, ifStallB, lsStallB);
    end
    step();
    ib.if_req_i = 0;
    repeat (3) step();
    @(negedge clk);
    nCmp++;
    if (ifStallB !== 32'd3 || qb.size() != 0) begin
      nBad++;
      $display("FAIL stall_hold ifcnt=%0d pending=%0d required 3 0",
               ifStallB, qb.size());
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idleInputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_latency();
    test_reset_mid();
`ifdef ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
